// File: rtl/wqe_dispatcher_pkg.sv
// Shared definitions for the WQE dispatcher: WQE layout, descriptor register
// offsets and the controller state encoding.
package wqe_dispatcher_pkg;

  localparam int WQE_W     = 116;
  localparam int OPCODE_W  = 5;
  localparam int DNUM_W    = 3;
  localparam int TID_W     = 8;
  localparam int LEN_W     = 9;
  localparam int ADDR_HI_W = 12;
  localparam int ADDR_ME_W = 32;
  localparam int ADDR_LO_W = 20;
  localparam int TOTAL_W   = 11;

  localparam logic [7:0] REG_ADDR_LO = 8'h00;
  localparam logic [7:0] REG_ADDR_HI = 8'h04;
  localparam logic [7:0] REG_CTL     = 8'h08;
  localparam logic [7:0] REG_KICK    = 8'h0C;

  // Field order is MSB first, so this struct is bit-exact with the FIFO word.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [DNUM_W-1:0]    data_num;
    logic [TID_W-1:0]     tid;
    logic [LEN_W-1:0]     len0;
    logic [LEN_W-1:0]     len1;
    logic [LEN_W-1:0]     len2;
    logic [LEN_W-1:0]     len3;
    logic [ADDR_HI_W-1:0] addr_hi;
    logic [ADDR_ME_W-1:0] addr_me;
    logic [ADDR_LO_W-1:0] addr_lo;
  } wqe_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_CHECK,
    ST_WR_LO,
    ST_WR_HI,
    ST_WR_CTL,
    ST_WR_KICK,
    ST_WAIT_DONE
  } state_t;

  function automatic logic [31:0] ctl_word(input wqe_t w, input logic [TOTAL_W-1:0] total);
    return {w.opcode, w.data_num, w.tid, 5'd0, total};
  endfunction

endpackage

// File: rtl/wqe_dispatcher_if.sv
// Work-FIFO pop ports and AVMM descriptor-write master bundled for the dispatcher.
interface wqe_dispatcher_if;
  import wqe_dispatcher_pkg::*;

  logic             SqPop;
  logic [WQE_W-1:0] SqData;
  logic             SqEmpty;
  logic             RqPop;
  logic [WQE_W-1:0] RqData;
  logic             RqEmpty;
  logic             DmaChipSelect;
  logic             DmaWrite;
  logic [7:0]       DmaAddress;
  logic [31:0]      DmaWriteData;
  logic [3:0]       DmaByteEnable;
  logic             DmaWaitRequest;
  logic             DmaDone;

  modport master (
    output SqPop, RqPop, DmaChipSelect, DmaWrite, DmaAddress, DmaWriteData, DmaByteEnable,
    input  SqData, SqEmpty, RqData, RqEmpty, DmaWaitRequest, DmaDone
  );

  modport slave (
    input  SqPop, RqPop, DmaChipSelect, DmaWrite, DmaAddress, DmaWriteData, DmaByteEnable,
    output SqData, SqEmpty, RqData, RqEmpty, DmaWaitRequest, DmaDone
  );
endinterface

// File: rtl/wqe_len_sum.sv
// Masked 4-way adder: sums the first data_num segment lengths of a WQE.
module wqe_len_sum
  import wqe_dispatcher_pkg::*;
(
  input  logic [LEN_W-1:0]   len0_i,
  input  logic [LEN_W-1:0]   len1_i,
  input  logic [LEN_W-1:0]   len2_i,
  input  logic [LEN_W-1:0]   len3_i,
  input  logic [DNUM_W-1:0]  data_num_i,
  output logic [TOTAL_W-1:0] total_o
);

  logic [TOTAL_W-1:0] seg0, seg1, seg2, seg3;

  // 4 x 511 = 2044 fits in 11 bits, so zero-extending first means no carry is lost.
  assign seg0 = (data_num_i > 3'd0) ? TOTAL_W'(len0_i) : '0;
  assign seg1 = (data_num_i > 3'd1) ? TOTAL_W'(len1_i) : '0;
  assign seg2 = (data_num_i > 3'd2) ? TOTAL_W'(len2_i) : '0;
  assign seg3 = (data_num_i > 3'd3) ? TOTAL_W'(len3_i) : '0;

  assign total_o = seg0 + seg1 + seg2 + seg3;

endmodule

// File: rtl/wqe_dispatcher.sv
// Pops WQEs from the send/receive work FIFOs (round-robin), validates them and
// programs one DMA descriptor at a time through four AVMM register writes.
module wqe_dispatcher
  import wqe_dispatcher_pkg::*;
#(
  parameter logic [7:0] DESC_BASE = 8'h00,
  parameter int         MAX_SEG   = 4
) (
  input  logic             clock,
  input  logic             reset,
  wqe_dispatcher_if.master bus,
  output logic             Busy,
  output logic [7:0]       BadWqeCount
);

  state_t             state_q;
  wqe_t               wqe_q;
  logic               qid_q;
  logic               rr_q;
  logic               sq_pop_q;
  logic               rq_pop_q;
  logic               cs_q;
  logic               busy_q;
  logic [7:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [7:0]         bad_cnt_q;
  logic [TOTAL_W-1:0] total_len;
  logic               pick_rq;
  logic               wqe_bad;

  wqe_len_sum u_len_sum (
    .len0_i     (wqe_q.len0),
    .len1_i     (wqe_q.len1),
    .len2_i     (wqe_q.len2),
    .len3_i     (wqe_q.len3),
    .data_num_i (wqe_q.data_num),
    .total_o    (total_len)
  );

  // rr_q = 1 gives RQ priority; only consulted when both queues hold work.
  assign pick_rq = bus.SqEmpty | (~bus.RqEmpty & rr_q);
  assign wqe_bad = (wqe_q.data_num == '0) || (int'(wqe_q.data_num) > MAX_SEG);

  // NOTE: state and outputs update with <= so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      qid_q     <= 1'b0;
      rr_q      <= 1'b0;
      sq_pop_q  <= 1'b0;
      rq_pop_q  <= 1'b0;
      cs_q      <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bad_cnt_q <= '0;
      // NOTE: wqe_q is left out of reset; it is always rewritten in LATCH before use.
    end else begin
      sq_pop_q <= 1'b0;
      rq_pop_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.SqEmpty || !bus.RqEmpty) begin
            qid_q    <= pick_rq;
            rr_q     <= ~pick_rq;
            sq_pop_q <= ~pick_rq;
            rq_pop_q <= pick_rq;
            busy_q   <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_LATCH;
        ST_LATCH: begin
          wqe_q   <= qid_q ? wqe_t'(bus.RqData) : wqe_t'(bus.SqData);
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (wqe_bad) begin
            if (bad_cnt_q != 8'hff) bad_cnt_q <= bad_cnt_q + 8'd1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cs_q    <= 1'b1;
            addr_q  <= DESC_BASE + REG_ADDR_LO;
            wdata_q <= {wqe_q.addr_me[11:0], wqe_q.addr_lo};
            state_q <= ST_WR_LO;
          end
        end
        ST_WR_LO: begin
          if (!bus.DmaWaitRequest) begin
            addr_q  <= DESC_BASE + REG_ADDR_HI;
            wdata_q <= {wqe_q.addr_hi, wqe_q.addr_me[31:12]};
            state_q <= ST_WR_HI;
          end
        end
        ST_WR_HI: begin
          if (!bus.DmaWaitRequest) begin
            addr_q  <= DESC_BASE + REG_CTL;
            wdata_q <= ctl_word(wqe_q, total_len);
            state_q <= ST_WR_CTL;
          end
        end
        ST_WR_CTL: begin
          if (!bus.DmaWaitRequest) begin
            addr_q  <= DESC_BASE + REG_KICK;
            wdata_q <= {31'd0, qid_q};
            state_q <= ST_WR_KICK;
          end
        end
        ST_WR_KICK: begin
          if (!bus.DmaWaitRequest) begin
            cs_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.DmaDone) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          cs_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.SqPop         = sq_pop_q;
  assign bus.RqPop         = rq_pop_q;
  assign bus.DmaChipSelect = cs_q;
  assign bus.DmaWrite      = cs_q;
  assign bus.DmaAddress    = addr_q;
  assign bus.DmaWriteData  = wdata_q;
  assign bus.DmaByteEnable = 4'hf;
  assign Busy              = busy_q;
  assign BadWqeCount       = bad_cnt_q;

endmodule

// File: tb/tb_wqe_dispatcher.sv
// Bench for wqe_dispatcher: FIFO and AVMM slave models plus a descriptor-level
// reference model that predicts every register write from the WQE fields.
module tb_wqe_dispatcher;
  import wqe_dispatcher_pkg::*;

  localparam logic [7:0] BASE    = 8'h20;
  localparam int         MAX_SEG = 4;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  num;
    logic [7:0]  tid;
    logic [8:0]  l0, l1, l2, l3;
    logic [63:0] addr;
  } item_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       busy;
  logic [7:0] bad_cnt;

  wqe_dispatcher_if bus ();

  wqe_dispatcher #(.DESC_BASE(BASE), .MAX_SEG(MAX_SEG)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .Busy        (busy),
    .BadWqeCount (bad_cnt)
  );

  always #5 clock = ~clock;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cycle        = 0;
  item_t       sq_q[$];
  item_t       rq_q[$];
  wr_t         exp_q[$];
  int          served_qid[$];
  int          acc_cycles[$];
  int          bad_model    = 0;
  int          acc_count    = 0;
  int          pop_cycle    = 0;
  int          first_cs_cyc = 0;
  int          hi_cs_cycles = 0;
  logic [31:0] last_ctl     = '0;
  logic        pend         = 1'b0;
  logic        pend_rq      = 1'b0;
  logic        hold         = 1'b0;
  logic [115:0] pend_bits   = '0;
  logic [7:0]  stall_addr   = '0;
  int          stall_cnt    = 0;
  logic        rand_wait    = 1'b0;
  logic        auto_done    = 1'b1;
  logic        rand_done    = 1'b0;
  int          done_delay   = 5;
  int          done_cnt     = 0;
  logic        stray_done   = 1'b0;
  logic        prev_cs      = 1'b0;
  logic        prev_stalled = 1'b0;
  logic [7:0]  prev_addr    = '0;
  logic [31:0] prev_data    = '0;

  function automatic logic [115:0] rand116();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[115:0];
  endfunction

  function automatic logic [115:0] to_bits(input item_t it);
    return {it.op, it.num, it.tid, it.l0, it.l1, it.l2, it.l3, it.addr};
  endfunction

  function automatic int seg_len(input item_t it, input int i);
    case (i)
      0: return int'(it.l0);
      1: return int'(it.l1);
      2: return int'(it.l2);
      default: return int'(it.l3);
    endcase
  endfunction

  // Descriptor model: what the controller register window must receive for one WQE.
  function automatic void expect_item(input item_t it, input int qid);
    int total = 0;
    wr_t w;
    if (it.num == 3'd0 || int'(it.num) > MAX_SEG) begin
      if (bad_model < 255) bad_model++;
      return;
    end
    for (int i = 0; i < int'(it.num); i++) total += seg_len(it, i);
    w.addr = BASE + 8'h00; w.data = 32'(it.addr % 64'h1_0000_0000); exp_q.push_back(w);
    w.addr = BASE + 8'h04; w.data = 32'(it.addr / 64'h1_0000_0000); exp_q.push_back(w);
    w.addr = BASE + 8'h08;
    w.data = (32'(it.op) << 27) | (32'(it.num) << 24) | (32'(it.tid) << 16) | 32'(total);
    exp_q.push_back(w);
    w.addr = BASE + 8'h0C; w.data = 32'(qid); exp_q.push_back(w);
  endfunction

  function automatic item_t make_item(input logic [4:0] op, input logic [2:0] num,
                                      input logic [7:0] tid, input int a, input int b,
                                      input int c, input int d, input logic [63:0] addr);
    item_t it;
    it.op = op; it.num = num; it.tid = tid; it.addr = addr;
    it.l0 = 9'(a); it.l1 = 9'(b); it.l2 = 9'(c); it.l3 = 9'(d);
    return it;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it = make_item(5'($urandom), 3'($urandom_range(1, 4)), 8'($urandom),
                   $urandom_range(0, 511), $urandom_range(0, 511),
                   $urandom_range(0, 511), $urandom_range(0, 511),
                   {$urandom(), $urandom()});
    if ($urandom_range(0, 4) == 0) it.num = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
    return it;
  endfunction

  task automatic push(input int to_rq, input item_t it);
    if (to_rq != 0) rq_q.push_back(it); else sq_q.push_back(it);
    bus.SqEmpty = (sq_q.size() == 0);
    bus.RqEmpty = (rq_q.size() == 0);
  endtask

  // Work-FIFO model: data appears the cycle after the pop and is garbage otherwise.
  always @(posedge clock) begin
    #1;
    cycle++;
    if (hold) begin
      bus.SqData = rand116();
      bus.RqData = rand116();
      hold = 1'b0;
    end
    if (pend) begin
      if (pend_rq) bus.RqData = pend_bits; else bus.SqData = pend_bits;
      hold = 1'b1;
      pend = 1'b0;
    end
    if (bus.SqPop || bus.RqPop) begin
      item_t it;
      tests_run++;
      if (bus.SqPop && bus.RqPop) begin
        tests_failed++;
        $display("FAIL dual_pop: SqPop=%0b RqPop=%0b, required not both", bus.SqPop, bus.RqPop);
      end
      tests_run++;
      if ((bus.RqPop && rq_q.size() == 0) || (!bus.RqPop && sq_q.size() == 0)) begin
        tests_failed++;
        $display("FAIL pop_on_empty: rq=%0b, queue sizes sq=%0d rq=%0d", bus.RqPop, sq_q.size(), rq_q.size());
      end else begin
        it = bus.RqPop ? rq_q.pop_front() : sq_q.pop_front();
        pend_bits = to_bits(it);
        pend_rq   = bus.RqPop;
        pend      = 1'b1;
        pop_cycle = cycle;
        served_qid.push_back(bus.RqPop ? 1 : 0);
        expect_item(it, bus.RqPop ? 1 : 0);
      end
    end
    bus.SqEmpty = (sq_q.size() == 0);
    bus.RqEmpty = (rq_q.size() == 0);
  end

  // AVMM slave model and write monitor.
  always @(negedge clock) begin
    if (bus.DmaChipSelect && bus.DmaAddress == stall_addr && stall_cnt > 0) begin
      bus.DmaWaitRequest = 1'b1;
      stall_cnt--;
    end else if (bus.DmaChipSelect && rand_wait) begin
      bus.DmaWaitRequest = ($urandom_range(0, 2) == 0);
    end else begin
      bus.DmaWaitRequest = 1'b0;
    end
    bus.DmaDone = stray_done;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus.DmaDone = 1'b1;
    end
    if (prev_stalled) begin
      tests_run++;
      if (!bus.DmaChipSelect || bus.DmaAddress !== prev_addr || bus.DmaWriteData !== prev_data) begin
        tests_failed++;
        $display("FAIL stall_stable: cs=%0b addr=%0h data=%0h, required cs=1 addr=%0h data=%0h",
                 bus.DmaChipSelect, bus.DmaAddress, bus.DmaWriteData, prev_addr, prev_data);
      end
    end
    if (bus.DmaChipSelect) begin
      tests_run++;
      if (bus.DmaWrite !== 1'b1 || bus.DmaByteEnable !== 4'hf) begin
        tests_failed++;
        $display("FAIL write_be: write=%0b be=%0h, required 1 and f", bus.DmaWrite, bus.DmaByteEnable);
      end
      if (!prev_cs) first_cs_cyc = cycle;
      if (bus.DmaAddress == BASE + 8'h04) hi_cs_cycles++;
      if (!bus.DmaWaitRequest) begin
        wr_t w;
        acc_count++;
        acc_cycles.push_back(cycle);
        if (bus.DmaAddress == BASE + 8'h08) last_ctl = bus.DmaWriteData;
        if (bus.DmaAddress == BASE + 8'h0C && auto_done)
          done_cnt = rand_done ? $urandom_range(1, 6) : done_delay;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write: addr=%0h data=%0h, required no write", bus.DmaAddress, bus.DmaWriteData);
        end else begin
          w = exp_q.pop_front();
          if (bus.DmaAddress !== w.addr || bus.DmaWriteData !== w.data) begin
            tests_failed++;
            $display("FAIL write_value: addr=%0h data=%0h, required addr=%0h data=%0h",
                     bus.DmaAddress, bus.DmaWriteData, w.addr, w.data);
          end
        end
      end
    end
    prev_cs      = bus.DmaChipSelect;
    prev_stalled = bus.DmaChipSelect && bus.DmaWaitRequest;
    prev_addr    = bus.DmaAddress;
    prev_data    = bus.DmaWriteData;
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    sq_q.delete(); rq_q.delete(); exp_q.delete(); served_qid.delete(); acc_cycles.delete();
    bus.SqEmpty = 1'b1; bus.RqEmpty = 1'b1;
    bad_model = 0; acc_count = 0; hi_cs_cycles = 0; done_cnt = 0; stall_cnt = 0;
    rand_wait = 1'b0; auto_done = 1'b1; rand_done = 1'b0; done_delay = 5; stray_done = 1'b0;
    reset = 1'b1;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(posedge clock); #2;
      n++;
      if (!busy && sq_q.size() == 0 && rq_q.size() == 0 && !pend && exp_q.size() == 0) quiet++;
      else quiet = 0;
    end
    tests_run++;
    if (quiet < 3) begin
      tests_failed++;
      $display("FAIL %s_timeout: not idle after %0d cycles (busy=%0b pending writes=%0d)", name, n, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clock); #2;
    tests_run++;
    if ({bus.SqPop, bus.RqPop, bus.DmaChipSelect, bus.DmaWrite, busy} !== 5'b0 ||
        bad_cnt !== 8'h00 || bus.DmaAddress !== 8'h00 || bus.DmaWriteData !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_values: pops=%0b%0b cs=%0b wr=%0b busy=%0b bad=%0h addr=%0h data=%0h, required all 0",
               bus.SqPop, bus.RqPop, bus.DmaChipSelect, bus.DmaWrite, busy, bad_cnt, bus.DmaAddress, bus.DmaWriteData);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    push(0, make_item(5'h03, 3'd2, 8'hA5, 100, 200, 7, 9, 64'h0123_4567_89AB_CDEF));
    wait_quiet("single", 200);
    tests_run++;
    if (acc_count != 4) begin
      tests_failed++; $display("FAIL single_count: %0d writes, required 4", acc_count);
    end
    tests_run++;
    if (acc_cycles.size() == 4 && (acc_cycles[3] - acc_cycles[0]) != 3) begin
      tests_failed++; $display("FAIL single_consecutive: span %0d cycles, required 3", acc_cycles[3] - acc_cycles[0]);
    end
    tests_run++;
    if (first_cs_cyc - pop_cycle != 3) begin
      tests_failed++; $display("FAIL single_latency: %0d cycles, required 3", first_cs_cyc - pop_cycle);
    end
    tests_run++;
    if (last_ctl[10:0] !== 11'd300) begin
      tests_failed++; $display("FAIL single_total: %0d, required 300", last_ctl[10:0]);
    end
  endtask

  task automatic test_round_robin();
    int want[4] = '{0, 1, 0, 1};
    do_reset();
    push(0, rand_item()); push(0, rand_item());
    push(1, rand_item()); push(1, rand_item());
    for (int i = 0; i < 2; i++) begin
      sq_q[i].num = 3'd3; rq_q[i].num = 3'd1;
    end
    wait_quiet("rr", 400);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (served_qid.size() <= i || served_qid[i] != want[i]) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d", i, (served_qid.size() > i) ? served_qid[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_waitreq();
    do_reset();
    stall_addr = BASE + 8'h04;
    stall_cnt  = 3;
    push(1, make_item(5'h11, 3'd4, 8'h3C, 1, 2, 3, 4, {$urandom(), $urandom()}));
    wait_quiet("wait", 200);
    tests_run++;
    if (hi_cs_cycles != 4) begin
      tests_failed++; $display("FAIL wait_hold: 0x04 held %0d cycles, required 4", hi_cs_cycles);
    end
    tests_run++;
    if (acc_count != 4) begin
      tests_failed++; $display("FAIL wait_count: %0d writes, required 4", acc_count);
    end
  endtask

  task automatic test_bad();
    do_reset();
    push(0, make_item(5'h01, 3'd0, 8'h01, 5, 5, 5, 5, 64'h1));
    push(0, make_item(5'h02, 3'd5, 8'h02, 6, 6, 6, 6, 64'h2));
    wait_quiet("bad", 200);
    tests_run++;
    if (acc_count != 0 || bad_cnt !== 8'd2) begin
      tests_failed++; $display("FAIL bad_drop: writes=%0d count=%0d, required 0 and 2", acc_count, bad_cnt);
    end
    push(0, make_item(5'h04, 3'd1, 8'h03, 77, 1, 1, 1, 64'hFFFF_0000_1234_5678));
    wait_quiet("bad_next", 200);
    tests_run++;
    if (acc_count != 4) begin
      tests_failed++; $display("FAIL bad_next: %0d writes, required 4", acc_count);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    push(0, make_item(5'h1F, 3'd4, 8'hFF, 511, 511, 511, 511, 64'hFFFF_FFFF_FFFF_FFFF));
    wait_quiet("maxlen", 200);
    tests_run++;
    if (last_ctl[10:0] !== 11'd2044) begin
      tests_failed++; $display("FAIL max_total: %0d, required 2044", last_ctl[10:0]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    auto_done = 1'b0;
    push(0, make_item(5'h05, 3'd7, 8'h00, 0, 0, 0, 0, 64'h0));
    push(0, make_item(5'h06, 3'd2, 8'h10, 10, 20, 0, 0, 64'hABCD));
    while (acc_count < 4 && n < 200) begin
      @(posedge clock); #2; n++;
    end
    tests_run++;
    if (!busy || bad_cnt !== 8'd1) begin
      tests_failed++; $display("FAIL mid_pre: busy=%0b bad=%0d, required 1 and 1", busy, bad_cnt);
    end
    reset = 1'b0;
    @(posedge clock); #2;
    tests_run++;
    if ({bus.SqPop, bus.RqPop, bus.DmaChipSelect, busy} !== 4'b0 || bad_cnt !== 8'h00 ||
        bus.DmaAddress !== 8'h00 || bus.DmaWriteData !== 32'h0) begin
      tests_failed++; $display("FAIL mid_reset: cs=%0b busy=%0b bad=%0h, required all 0", bus.DmaChipSelect, busy, bad_cnt);
    end
    reset = 1'b1; bad_model = 0;
    stray_done = 1'b1;
    @(posedge clock); #2;
    stray_done = 1'b0;
    repeat (4) @(posedge clock); #2;
    tests_run++;
    if (busy || acc_count != 4) begin
      tests_failed++; $display("FAIL stray_done: busy=%0b writes=%0d, required 0 and 4", busy, acc_count);
    end
    auto_done = 1'b1;
    push(1, make_item(5'h07, 3'd3, 8'h20, 1, 2, 3, 0, 64'h55));
    wait_quiet("mid_after", 200);
    tests_run++;
    if (acc_count != 8) begin
      tests_failed++; $display("FAIL mid_after: %0d writes, required 8", acc_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_wait = 1'b1;
    rand_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push($urandom_range(0, 1), rand_item());
      repeat ($urandom_range(0, 12)) @(posedge clock);
      #2;
    end
    wait_quiet("random", 5000);
    tests_run++;
    if (served_qid.size() != 40) begin
      tests_failed++; $display("FAIL random_served: %0d, required 40", served_qid.size());
    end
    tests_run++;
    if (int'(bad_cnt) != bad_model) begin
      tests_failed++; $display("FAIL random_bad: %0d, required %0d", bad_cnt, bad_model);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.SqEmpty = 1'b1; bus.RqEmpty = 1'b1;
    bus.SqData = '0; bus.RqData = '0;
    bus.DmaWaitRequest = 1'b0; bus.DmaDone = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_waitreq();
    test_bad();
    test_max_len();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
